// File: rtl/food_placer.sv
// food_placer: picks a free board cell for new food from the rng stream.
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   place_req      in   one-cycle pulse: place new food
//   rand_x/rand_y  in   random column/row from the rng
//   query_x/_y     out  registered occupancy lookup address
//   query_occupied in   snake on the query cell, valid one clock after the address changes
//   food_x/_y      out  current food cell
//   food_valid     out  food position valid
//   busy           out  placement in progress
//   place_done     out  one-cycle pulse: food placed
//   board_full     out  no free cell found
module food_placer #(
    parameter int BOARD_WIDTH       = 40,
    parameter int BOARD_HEIGHT      = 30,
    parameter int BOARD_WIDTH_BITS  = 6,
    parameter int BOARD_HEIGHT_BITS = 5,
    parameter int MAX_TRIES         = 8,
    parameter int TRY_BITS          = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         place_req,
    input  logic [BOARD_WIDTH_BITS-1:0]  rand_x,
    input  logic [BOARD_HEIGHT_BITS-1:0] rand_y,
    output logic [BOARD_WIDTH_BITS-1:0]  query_x,
    output logic [BOARD_HEIGHT_BITS-1:0] query_y,
    input  logic                         query_occupied,
    output logic [BOARD_WIDTH_BITS-1:0]  food_x,
    output logic [BOARD_HEIGHT_BITS-1:0] food_y,
    output logic                         food_valid,
    output logic                         busy,
    output logic                         place_done,
    output logic                         board_full
);
    localparam logic [BOARD_WIDTH_BITS-1:0]  X_LAST = BOARD_WIDTH_BITS'(BOARD_WIDTH - 1);
    localparam logic [BOARD_HEIGHT_BITS-1:0] Y_LAST = BOARD_HEIGHT_BITS'(BOARD_HEIGHT - 1);
    localparam logic [TRY_BITS-1:0]          T_MAX  = TRY_BITS'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, RAND_WAIT, RAND_CHK, SCAN_WAIT, SCAN_CHK} state_t;

    state_t              state;
    logic [TRY_BITS-1:0] tries;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tries      <= '0;
            query_x    <= '0;
            query_y    <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            place_done <= 1'b0;
            board_full <= 1'b0;
        end else begin
            place_done <= 1'b0;
            case (state)
                IDLE: if (place_req) begin
                    query_x    <= rand_x;
                    query_y    <= rand_y;
                    tries      <= TRY_BITS'(1);
                    food_valid <= 1'b0;
                    board_full <= 1'b0;
                    busy       <= 1'b1;
                    state      <= RAND_WAIT;
                end
                RAND_WAIT: state <= RAND_CHK;
                RAND_CHK: if (!query_occupied) begin
                    food_x     <= query_x;
                    food_y     <= query_y;
                    food_valid <= 1'b1;
                    place_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else if (tries < T_MAX) begin
                    query_x <= rand_x;
                    query_y <= rand_y;
                    tries   <= tries + 1'b1;
                    state   <= RAND_WAIT;
                end else begin
                    // random probing exhausted: deterministic scan guarantees termination
                    query_x <= '0;
                    query_y <= '0;
                    state   <= SCAN_WAIT;
                end
                SCAN_WAIT: state <= SCAN_CHK;
                SCAN_CHK: if (!query_occupied) begin
                    food_x     <= query_x;
                    food_y     <= query_y;
                    food_valid <= 1'b1;
                    place_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else if (query_x == X_LAST && query_y == Y_LAST) begin
                    board_full <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else begin
                    query_x <= (query_x == X_LAST) ? '0 : query_x + 1'b1;
                    query_y <= (query_x == X_LAST) ? query_y + 1'b1 : query_y;
                    state   <= SCAN_WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed checks of food_placer against a registered occupancy model.
module tb_food_placer;
    localparam int W = 40;
    localparam int H = 30;

    logic       clk = 0;
    logic       reset = 0;
    logic       place_req = 0;
    logic [5:0] rand_x = 0;
    logic [4:0] rand_y = 0;
    logic [5:0] query_x;
    logic [4:0] query_y;
    logic       query_occupied = 0;
    logic [5:0] food_x;
    logic [4:0] food_y;
    logic       food_valid, busy, place_done, board_full;

    logic occ [H][W];
    int checks = 0;
    int errors = 0;
    int n, pulses;

    food_placer dut (
        .clk(clk), .reset(reset), .place_req(place_req),
        .rand_x(rand_x), .rand_y(rand_y),
        .query_x(query_x), .query_y(query_y), .query_occupied(query_occupied),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .place_done(place_done), .board_full(board_full)
    );

    always #5 clk = ~clk;

    // one-cycle-latency occupancy memory
    always @(posedge clk) query_occupied <= occ[int'(query_y)][int'(query_x)];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                occ[y][x] = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pulse place_req so that it is sampled at the next edge (E0); returns just after E0
    task automatic request;
        place_req = 1;
        tick();
        place_req = 0;
    endtask

    // edges after E0 until place_done is seen high
    task automatic wait_done(input int lim, output int cnt);
        cnt = 0;
        while (cnt < lim) begin
            tick();
            cnt++;
            if (place_done) return;
        end
    endtask

    initial begin
        fill(1'b0);
        #2;
        check("rst_food_x", food_x, 0);
        check("rst_query", {query_x, query_y}, 0);
        check("rst_flags", {food_valid, busy, place_done, board_full}, 0);
        tick();
        reset = 1;
        tick();

        // reset in the middle of a placement
        rand_x = 9; rand_y = 9;
        request();
        check("mid_busy", busy, 1);
        #2 reset = 0;
        #1;
        check("mid_rst_outs", {busy, place_done, food_valid, query_x, query_y}, 0);
        tick();
        reset = 1;
        tick(); tick();
        check("mid_rst_quiet", {busy, place_done}, 0);

        // empty board, single probe
        rand_x = 12; rand_y = 7;
        request();
        check("p1_query", {query_x, query_y}, {6'd12, 5'd7});
        check("p1_busy", busy, 1);
        tick();
        check("p1_e1_done", place_done, 0);
        tick();
        check("p1_e2_done", place_done, 1);
        check("p1_food", {food_x, food_y, food_valid, busy}, {6'd12, 5'd7, 1'b1, 1'b0});
        tick();
        check("p1_pulse_len", place_done, 0);

        // (12,7) occupied, second rng sample free
        occ[7][12] = 1;
        rand_x = 12; rand_y = 7;
        request();
        rand_x = 3; rand_y = 4;
        wait_done(50, n);
        check("p2_lat", n, 4);
        check("p2_food", {food_x, food_y, food_valid}, {6'd3, 5'd4, 1'b1});

        // rng keeps hitting occupied cells; row 0 full except (5,0)
        rand_x = 20; rand_y = 15;
        occ[15][20] = 1;
        for (int x = 0; x < W; x++) occ[0][x] = (x != 5);
        request();
        wait_done(200, n);
        check("p3_lat", n, 2 * 8 + 2 * 6);
        check("p3_food", {food_x, food_y, food_valid, board_full}, {6'd5, 5'd0, 1'b1, 1'b0});

        // fully occupied board
        fill(1'b1);
        request();
        n = 0;
        pulses = 0;
        while (n < 3000) begin
            tick();
            n++;
            pulses += place_done;
            if (!busy) break;
        end
        check("full_lat", n, 2 * 8 + 2 * W * H);
        check("full_pulses", pulses, 0);
        check("full_flags", {board_full, food_valid}, 2'b10);
        check("full_hold_food", {food_x, food_y}, {6'd5, 5'd0});
        check("full_query_end", {query_x, query_y}, {6'd39, 5'd29});
        tick(); tick();
        check("full_sticky", board_full, 1);

        // a later request clears board_full
        fill(1'b0);
        rand_x = 1; rand_y = 2;
        request();
        check("clr_full", board_full, 0);
        wait_done(50, n);
        check("clr_food", {food_x, food_y, food_valid}, {6'd1, 5'd2, 1'b1});

        // requests while busy are ignored
        fill(1'b0);
        for (int x = 1; x < W; x++) occ[0][x] = 1;
        occ[15][20] = 1;
        rand_x = 20; rand_y = 15;
        request();
        place_req = 1;
        pulses = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 15) place_req = 0;
            if (place_done && n == 0) n = i + 1;
            pulses += place_done;
        end
        check("busy_pulses", pulses, 1);
        check("busy_lat", n, 2 * 8 + 2);
        check("busy_food", {food_x, food_y, busy}, {6'd0, 5'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
